// File: rtl/cpri_rx_sched_pkg.sv
// rtl/cpri_rx_sched_pkg.sv - shared types, constants and starve-limit helper for cpri_rx_sched
package cpri_rx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        BURST,
        GAP
    } sched_state_e;

    localparam int CHIP_FIRST_ADDR = 7;
    localparam int CHIP_LAST_ADDR  = 90;
    localparam int DEF_CHIP_LEN    = 84;

    // Four full round-robin rotations without service counts as starvation.
    function automatic int starve_limit(input int num_ch, input int chip_len, input int gap_cycles);
        return num_ch * (chip_len + gap_cycles + 1) * 4;
    endfunction

endpackage

// File: rtl/cpri_rx_sched_rr_arbiter.sv
// rtl/cpri_rx_sched_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr_i
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic              found_o,
    output logic [CH_W-1:0]   idx_o
);

    int cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(ptr_i) + i) % NUM_CH;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cpri_rx_sched.sv
// rtl/cpri_rx_sched.sv - round-robin chip-read scheduler for CPRI rx lane buffers
// Optional per-lane chip counters and starvation flags: CPRI_RX_SCHED_STATS_EN
module cpri_rx_sched
    import cpri_rx_sched_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int CHIP_LEN   = DEF_CHIP_LEN,
    parameter  int GAP_CYCLES = 3,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NUM_CH-1:0] i_ch_avail,
    input  logic              i_ds_ready,
    output logic [NUM_CH-1:0] o_ch_rready,
    output logic              o_grant_vld,
    output logic [CH_W-1:0]   o_grant_ch,
    output logic [6:0]        o_word_cnt,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_busy
`ifdef CPRI_RX_SCHED_STATS_EN
    ,
    output logic [15:0]       o_chip_cnt [NUM_CH],
    output logic [NUM_CH-1:0] o_starve
`endif
);

    sched_state_e    state_q, state_d;
    logic [CH_W-1:0] grant_ch_q, grant_ch_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [6:0]      word_cnt_q, word_cnt_d;
    logic [15:0]     gap_cnt_q, gap_cnt_d;

    logic            arb_found;
    logic [CH_W-1:0] arb_idx;
    logic            word_adv;
    logic            last_word;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i   (i_ch_avail),
        .ptr_i   (ptr_q),
        .found_o (arb_found),
        .idx_o   (arb_idx)
    );

    assign word_adv  = (state_q == BURST) && i_ds_ready;
    assign last_word = (word_cnt_q == 7'(CHIP_LEN - 1));

    always_comb begin
        state_d    = state_q;
        grant_ch_d = grant_ch_q;
        ptr_d      = ptr_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_enable) state_d = ARB;
            end
            ARB: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (arb_found) begin
                    grant_ch_d = arb_idx;
                    word_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // i_enable and i_ch_avail are ignored here: a started chip always completes.
                if (word_adv) begin
                    if (last_word) begin
                        word_cnt_d = '0;
                        gap_cnt_d  = '0;
                        ptr_d      = (grant_ch_q == CH_W'(NUM_CH - 1)) ? '0 : grant_ch_q + CH_W'(1);
                        state_d    = (GAP_CYCLES == 0) ? ARB : GAP;
                    end else begin
                        word_cnt_d = word_cnt_q + 7'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 16'(GAP_CYCLES - 1)) state_d = ARB;
                else                                  gap_cnt_d = gap_cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            grant_ch_q <= '0;
            ptr_q      <= '0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_ch_q <= grant_ch_d;
            ptr_q      <= ptr_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        o_ch_rready = '0;
        if (word_adv) o_ch_rready[grant_ch_q] = 1'b1;
    end

    assign o_grant_vld = (state_q == BURST);
    assign o_grant_ch  = grant_ch_q;
    assign o_word_cnt  = word_cnt_q;
    assign o_sof       = word_adv && (word_cnt_q == 7'd0);
    assign o_eof       = word_adv && last_word;
    assign o_busy      = (state_q != IDLE);

`ifdef CPRI_RX_SCHED_STATS_EN
    localparam int STARVE_LIM = starve_limit(NUM_CH, CHIP_LEN, GAP_CYCLES);

    logic [31:0] wait_q [NUM_CH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                o_chip_cnt[c] <= '0;
                wait_q[c]     <= '0;
            end
            o_starve <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (o_eof && (grant_ch_q == CH_W'(c))) o_chip_cnt[c] <= o_chip_cnt[c] + 16'd1;
                if (!i_ch_avail[c] ||
                    ((state_q == ARB) && i_enable && arb_found && (arb_idx == CH_W'(c)))) begin
                    wait_q[c] <= '0;
                end else if (wait_q[c] != '1) begin
                    wait_q[c] <= wait_q[c] + 32'd1;
                end
                if (wait_q[c] >= 32'(STARVE_LIM)) o_starve[c] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpri_rx_sched.sv
// tb/tb_cpri_rx_sched.sv - directed self-checking bench for cpri_rx_sched
module tb_cpri_rx_sched;

    localparam int CHIP_LEN = 84;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic [3:0] i_ch_avail;
    logic       i_ds_ready;
    logic [3:0] o_ch_rready;
    logic       o_grant_vld;
    logic [1:0] o_grant_ch;
    logic [6:0] o_word_cnt;
    logic       o_sof;
    logic       o_eof;
    logic       o_busy;
`ifdef CPRI_RX_SCHED_STATS_EN
    logic [15:0] o_chip_cnt [4];
    logic [3:0]  o_starve;
`endif

    cpri_rx_sched #(.NUM_CH(4), .CHIP_LEN(CHIP_LEN), .GAP_CYCLES(3)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_ch_avail  (i_ch_avail),
        .i_ds_ready  (i_ds_ready),
        .o_ch_rready (o_ch_rready),
        .o_grant_vld (o_grant_vld),
        .o_grant_ch  (o_grant_ch),
        .o_word_cnt  (o_word_cnt),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_busy      (o_busy)
`ifdef CPRI_RX_SCHED_STATS_EN
        ,
        .o_chip_cnt  (o_chip_cnt),
        .o_starve    (o_starve)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int leak  = 0;
    int multi = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #2;
        if ($countones(o_ch_rready) > 1) multi++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rready"},   int'(o_ch_rready), 0);
        check({tag, "_grantvld"}, int'(o_grant_vld), 0);
        check({tag, "_grantch"},  int'(o_grant_ch),  0);
        check({tag, "_wordcnt"},  int'(o_word_cnt),  0);
        check({tag, "_sof"},      int'(o_sof),       0);
        check({tag, "_eof"},      int'(o_eof),       0);
        check({tag, "_busy"},     int'(o_busy),      0);
    endtask

    task automatic do_reset(input string tag);
        i_reset = 1'b1;
        cyc();
        check_idle(tag);
        i_reset = 1'b0;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        #1;
        while (!o_grant_vld && n < 1000) begin
            if (o_ch_rready != 4'b0) leak++;
            cyc();
            n++;
        end
    endtask

    task automatic run_chip(input int ch, input bit toggle, input int drop_at,
                            input string tag, output int cycles);
        int   w;
        int   bad;
        logic ds;
        w      = 0;
        bad    = 0;
        cycles = 0;
        while (o_grant_vld && cycles < 1000) begin
            ds = toggle ? ((cycles % 2) == 0) : 1'b1;
            i_ds_ready = ds;
            if (w == drop_at) i_enable = 1'b0;
            #1;
            if (int'(o_grant_ch) != ch) bad++;
            if (o_ch_rready != (ds ? 4'(1 << ch) : 4'b0)) bad++;
            if (int'(o_word_cnt) != w) bad++;
            if (o_sof != (ds && w == 0)) bad++;
            if (o_eof != (ds && w == CHIP_LEN - 1)) bad++;
            if (ds) w++;
            cycles++;
            cyc();
        end
        i_ds_ready = 1'b1;
        check({tag, "_words"}, w, CHIP_LEN);
        check({tag, "_seq"}, bad, 0);
    endtask

    initial begin
        int n;
        int c;
        int g;
        i_reset    = 1'b1;
        i_enable   = 1'b0;
        i_ch_avail = 4'b0;
        i_ds_ready = 1'b0;
        cyc();
        do_reset("rst");

        // single requester: latency, chip shape, re-grant period
        i_enable   = 1'b1;
        i_ch_avail = 4'b0001;
        i_ds_ready = 1'b1;
        wait_grant(n);
        check("t1_latency", n, 2);
        check("t1_ch", int'(o_grant_ch), 0);
        run_chip(0, 1'b0, -1, "t1a", c);
        check("t1_len", c, 84);
        wait_grant(n);
        check("t1_regrant", n, 4);
        check("t1_ch2", int'(o_grant_ch), 0);
        run_chip(0, 1'b0, -1, "t1b", c);
`ifdef CPRI_RX_SCHED_STATS_EN
        check("t1_chipcnt0", int'(o_chip_cnt[0]), 2);
`endif

        // all lanes requesting: strict rotation from lane 0
        do_reset("t2rst");
        i_ch_avail = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            if (k == 0) check("t2_latency", n, 2);
            else        check("t2_gap", n, 4);
            check("t2_order", int'(o_grant_ch), k % 4);
            run_chip(k % 4, 1'b0, -1, "t2", c);
        end

        // lane 1 with downstream ready toggling every cycle
        i_ch_avail = 4'b0010;
        wait_grant(n);
        check("t3_ch", int'(o_grant_ch), 1);
        run_chip(1, 1'b1, -1, "t3", c);
        check("t3_cycles", c, 167);

        // pointer 2, requests 1011 -> lane 3 then lane 0
        i_ch_avail = 4'b1011;
        wait_grant(n);
        check("t6_first", int'(o_grant_ch), 3);
        run_chip(3, 1'b0, -1, "t6a", c);
`ifdef CPRI_RX_SCHED_STATS_EN
        check("t6_chipcnt3", int'(o_chip_cnt[3]), 2);
`endif
        wait_grant(n);
        check("t6_second", int'(o_grant_ch), 0);
        i_ch_avail = 4'b0100;
        run_chip(0, 1'b0, -1, "t6b", c);

        // enable dropped mid-chip on lane 2
        wait_grant(n);
        check("t4_ch", int'(o_grant_ch), 2);
        run_chip(2, 1'b0, 40, "t4", c);
        check("t4_len", c, 84);
        n = 0;
        while (o_busy && n < 100) begin
            cyc();
            n++;
        end
        check("t4_wind_down", n, 4);
        g = 0;
        repeat (200) begin
            cyc();
            if (o_grant_vld || o_busy) g++;
        end
        check("t4_quiet", g, 0);

        // reset in the middle of a chip; pointer must return to lane 0
        i_ch_avail = 4'b0001;
        i_enable   = 1'b1;
        wait_grant(n);
        check("t5_ch", int'(o_grant_ch), 0);
        repeat (50) cyc();
        check("t5_word50", int'(o_word_cnt), 50);
        do_reset("t5rst");
        i_ch_avail = 4'b1111;
        wait_grant(n);
        check("t5_latency", n, 2);
        check("t5_ptr0", int'(o_grant_ch), 0);

        check("rready_outside_burst", leak, 0);
        check("rready_onehot", multi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
